cache_ctrl: RTL

//   Sequencing controller for the direct-mapped `cache` (one word per line).
//   - Sits between the core's load/store stage and the memory port.
//   - Hit path: lookup only. Read miss: fetch the word from memory, fill the line, respond.
//   - Writes: write-through, no-write-allocate.
//   - Keeps saturating hit and miss counters for performance monitoring.

---
 rtl/cache_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, one-word-per-line cache:
// lookup on hit, memory fetch and fill on read miss, write-through without allocate.
module cache_ctrl #(
    parameter int NUM_CACHE_LINES = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  cache_read_write,
    output logic [ADDR_WIDTH-1:0] cache_inp,
    output logic [DATA_WIDTH-1:0] cache_data_in,
    output logic                  cache_valid_in,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_data_out,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        FILL    = 3'd4,
        WR_REQ  = 3'd5,
        WR_WAIT = 3'd6
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic                  hit_inc, miss_inc, resp_set;
    logic [DATA_WIDTH-1:0] resp_data_nxt;

    // Handshakes: a core request transfers on a cycle where req_valid && req_ready;
    // a memory request transfers on a cycle where mem_req_valid && mem_req_ready,
    // and its fields come from the request registers so they hold until then.
    // mem_resp_valid is a single-cycle strobe with no back-pressure.

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP: begin
                if (write_q)        state_nxt = WR_REQ;
                else if (cache_hit) state_nxt = IDLE;
                else                state_nxt = RD_REQ;
            end
            RD_REQ:  if (mem_req_ready)  state_nxt = RD_WAIT;
            RD_WAIT: if (mem_resp_valid) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            WR_REQ:  if (mem_req_ready)  state_nxt = WR_WAIT;
            WR_WAIT: if (mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = (state == IDLE);
        mem_req_valid    = (state == RD_REQ) || (state == WR_REQ);
        cache_read_write = 1'b0;
        cache_valid_in   = 1'b0;
        cache_data_in    = wdata_q;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        resp_set         = 1'b0;
        resp_data_nxt    = '0;
        case (state)
            LOOKUP: begin
                hit_inc  = cache_hit;
                miss_inc = !cache_hit;
                if (cache_hit && write_q) begin
                    cache_read_write = 1'b1;
                    cache_valid_in   = 1'b1;
                end
                if (cache_hit && !write_q) begin
                    resp_set      = 1'b1;
                    resp_data_nxt = cache_data_out;
                end
            end
            FILL: begin
                cache_read_write = 1'b1;
                cache_valid_in   = 1'b1;
                cache_data_in    = fill_q;
                resp_set         = 1'b1;
                resp_data_nxt    = fill_q;
            end
            WR_WAIT: resp_set = mem_resp_valid;
            default: ;
        endcase
        // The cache is not reset with us, so a reset cycle must never write it.
        if (reset) begin
            cache_read_write = 1'b0;
            cache_valid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            fill_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (state == RD_WAIT && mem_resp_valid) fill_q <= mem_resp_data;
            resp_valid <= resp_set;
            resp_rdata <= resp_data_nxt;
            if (hit_inc && hit_count != '1)   hit_count  <= hit_count + 1'b1;
            if (miss_inc && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end

    assign cache_inp     = addr_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_write = write_q;
    assign mem_req_wdata = wdata_q;
    assign dbg_state     = state;

endmodule
